// File: rtl/ofm_writer.sv
// ----------------------------------------------------------------------------
// ofm_writer
//   Tail of the accumulator pipeline. Takes 48-bit beats over a valid/ready
//   stream, repacks them little-endian into 32-bit words and writes those
//   words to consecutive output feature-map SRAM addresses starting at a
//   configured base address. The address wraps modulo 2^ADDR_W. An odd beat
//   count leaves a 16-bit tail, which is written zero-padded. Completion is
//   reported by a one-cycle done pulse and a sticky irq.
//
// Ports
//   clk      : block clock
//   rst      : synchronous active-high reset
//   start    : one-cycle pulse; latches base/count (honoured only when idle)
//   base     : first SRAM word address of the layer
//   count    : number of 48-bit beats to consume
//   s_data   : input beat
//   s_valid  : input beat valid
//   s_ready  : block accepts a beat this cycle (decoded from registers)
//   wr_en    : SRAM write strobe (registered)
//   wr_addr  : SRAM word address (registered)
//   wr_data  : SRAM write data (registered)
//   busy     : high while consuming or draining
//   done     : one-cycle completion pulse, coincident with the last wr_en
//   irq      : sticky completion interrupt
//   irq_clr  : clears irq at the next edge (a same-cycle completion wins)
// ----------------------------------------------------------------------------
module ofm_writer #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]  count,
   input  logic [47:0]       s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              irq,
   input  logic              irq_clr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   state_t            state_r;
   state_t            state_nxt_s;

   // Packing buffer: valid data occupies bits [lvl_r-1:0], everything above
   // is kept zero so a new beat can simply be OR-ed in at the fill offset.
   logic [79:0]       buf_r;
   logic [79:0]       buf_nxt_s;
   logic [79:0]       buf_eff_s;
   logic [6:0]        lvl_r;
   logic [6:0]        lvl_nxt_s;
   logic [6:0]        lvl_eff_s;

   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W-1:0] ptr_nxt_s;
   logic [CNT_W-1:0]  left_r;
   logic [CNT_W-1:0]  left_nxt_s;

   logic              wr_en_r;
   logic              wr_en_nxt_s;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [ADDR_W-1:0] wr_addr_nxt_s;
   logic [31:0]       wr_data_r;
   logic [31:0]       wr_data_nxt_s;
   logic              irq_r;
   logic              irq_nxt_s;

   logic              active_s;
   logic              drain_s;
   logic              pad_s;
   logic              ready_s;
   logic              accept_s;

   // Drain decision and the post-drain view of the buffer used for appends.
   always_comb begin
      active_s = (state_r == ST_RUN) || (state_r == ST_FLUSH);
      drain_s  = active_s && (lvl_r >= 7'd32);
      // The 16-bit tail only exists once all beats are in.
      pad_s    = (state_r == ST_FLUSH) && (lvl_r == 7'd16);
      if (drain_s) begin
         buf_eff_s = {32'h0000_0000, buf_r[79:32]};
         lvl_eff_s = lvl_r - 7'd32;
      end else begin
         buf_eff_s = buf_r;
         lvl_eff_s = lvl_r;
      end
      // A beat fits when the post-drain level leaves 48 free bits; inside a
      // run this only fails at a full 80-bit buffer.
      ready_s  = (state_r == ST_RUN) && (left_r != CNT_ZERO) && (lvl_eff_s <= 7'd32);
      accept_s = s_valid && ready_s;
   end

   // Next values for buffer, pointers, write port and interrupt.
   always_comb begin
      buf_nxt_s     = buf_eff_s;
      lvl_nxt_s     = lvl_eff_s;
      ptr_nxt_s     = ptr_r;
      left_nxt_s    = left_r;
      wr_en_nxt_s   = 1'b0;
      wr_addr_nxt_s = wr_addr_r;
      wr_data_nxt_s = wr_data_r;

      if (drain_s) begin
         wr_en_nxt_s   = 1'b1;
         wr_addr_nxt_s = ptr_r;
         wr_data_nxt_s = buf_r[31:0];
         ptr_nxt_s     = ptr_r + ADDR_ONE;
      end else if (pad_s) begin
         wr_en_nxt_s   = 1'b1;
         wr_addr_nxt_s = ptr_r;
         wr_data_nxt_s = {16'h0000, buf_r[15:0]};
         ptr_nxt_s     = ptr_r + ADDR_ONE;
         buf_nxt_s     = 80'h0;
         lvl_nxt_s     = 7'd0;
      end else begin
         wr_en_nxt_s   = 1'b0;
      end

      if (accept_s) begin
         buf_nxt_s  = buf_eff_s | ({32'h0000_0000, s_data} << lvl_eff_s);
         lvl_nxt_s  = lvl_eff_s + 7'd48;
         left_nxt_s = left_r - CNT_ONE;
      end else begin
         left_nxt_s = left_r;
      end

      // Configuration is captured only from idle; later starts are ignored.
      if ((state_r == ST_IDLE) && start) begin
         ptr_nxt_s  = base;
         left_nxt_s = count;
         buf_nxt_s  = 80'h0;
         lvl_nxt_s  = 7'd0;
      end else begin
         ptr_nxt_s  = ptr_nxt_s;
      end

      // Setting on completion takes priority over a same-cycle clear.
      if (state_r == ST_DONE) begin
         irq_nxt_s = 1'b1;
      end else if (irq_clr) begin
         irq_nxt_s = 1'b0;
      end else begin
         irq_nxt_s = irq_r;
      end
   end

   // Control FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (count == CNT_ZERO) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (left_nxt_s == CNT_ZERO) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Leaving with an empty buffer means the final word (full or
            // padded) was issued on this edge, so done lines up with it.
            if (lvl_nxt_s == 7'd0) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Control FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath, write-port and interrupt registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r     <= 80'h0;
         lvl_r     <= 7'd0;
         ptr_r     <= ADDR_ZERO;
         left_r    <= CNT_ZERO;
         wr_en_r   <= 1'b0;
         wr_addr_r <= ADDR_ZERO;
         wr_data_r <= 32'h0000_0000;
         irq_r     <= 1'b0;
      end else begin
         buf_r     <= buf_nxt_s;
         lvl_r     <= lvl_nxt_s;
         ptr_r     <= ptr_nxt_s;
         left_r    <= left_nxt_s;
         wr_en_r   <= wr_en_nxt_s;
         wr_addr_r <= wr_addr_nxt_s;
         wr_data_r <= wr_data_nxt_s;
         irq_r     <= irq_nxt_s;
      end
   end

   assign s_ready = ready_s;
   assign wr_en   = wr_en_r;
   assign wr_addr = wr_addr_r;
   assign wr_data = wr_data_r;
   assign busy    = active_s;
   assign done    = (state_r == ST_DONE);
   assign irq     = irq_r;

endmodule

// File: doc/ofm_writer.md
Name: ofm_writer

Overview:
- Consumer end of the accumulator pipeline's 48-bit output stream (valid/ready).
- Repacks 48-bit beats into 32-bit words (little-endian, LSB first) and writes them to consecutive addresses of the output feature-map SRAM, starting at a configured base.
- Signals completion with a one-cycle done pulse and a sticky interrupt. The sticky interrupt is cleared by software through a clear strobe.

Parameters:
- ADDR_W, 10, width of the SRAM word address.
- CNT_W, 9, width of the beat-count configuration field (matches the layer size field).

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches base and count; ignored unless IDLE.
- base  in  ADDR_W  first SRAM word address for this layer.
- count  in  CNT_W  number of 48-bit beats to consume.
- s_data  in  48  input beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat this cycle.
- wr_en  out  1  SRAM write strobe (registered).
- wr_addr  out  ADDR_W  SRAM word address (registered).
- wr_data  out  32  SRAM write data (registered).
- busy  out  1  high in RUN/FLUSH.
- done  out  1  one-cycle completion pulse.
- irq  out  1  sticky completion interrupt.
- irq_clr  in  1  clears irq.

Behaviour:
- Interface timing: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - Outputs: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, irq=0.
  - Internal: FSM=IDLE, fill level L=0, buffer cleared.
  - Reset mid-operation discards partial data and issues no done.
- Stream model:
  - Beat k occupies stream bits [48k+47:48k].
  - SRAM word j is stream bits [32j+31:32j].
  - Word j is written to wr_addr = base+j, modulo 2^ADDR_W (wraps silently).
  - Total words = ceil(3*count/2).
- Buffer:
  - 80-bit register; fill level L in {0,16,32,48,64,80}.
- Per-cycle operation in RUN/FLUSH:
  - If L>=32 at the clock edge: register wr_en=1, wr_data=buf[31:0], wr_addr=ptr. Then shift the buffer right by 32, set L_eff=L-32, and increment ptr.
  - Otherwise L_eff=L and wr_en=0.
  - s_ready (combinational from registers) = (state==RUN) && beats_left!=0 && (L_eff+48 <= 80). Within a run this deasserts only at L=80.
  - On s_valid&&s_ready: append s_data at bit offset L_eff, set L=L_eff+48, decrement beats_left.
  - A write and an accept in the same cycle are both performed.
  - s_data is sampled only on handshake. s_valid without s_ready holds no state.
- Latency: a beat accepted at edge t with L=0 produces its first wr_en after edge t+1.
- FSM:
  - IDLE: on start, latch base into ptr and count into beats_left. Go to RUN; if count==0 go straight to DONE.
  - RUN: when beats_left==0 after an accept (or already 0), go to FLUSH.
  - FLUSH:
    - Continue draining words while L>=32.
    - If L==16, write a padded word {16'h0, buf[15:0]} and set L=0.
    - When L reaches 0 with the last write issued, go to DONE.
  - DONE: done=1 for exactly one cycle. This is the cycle in which the final wr_en is visible; for count==0 it is the cycle after start. Set irq=1, then go to IDLE.
- irq:
  - Sticky until irq_clr=1, which clears it at the next edge.
  - If irq_clr and a DONE set occur in the same cycle, set wins.
- start while busy or in DONE is ignored; configuration is not re-latched.
- busy is high in RUN and FLUSH only.
- wr_en is never asserted in IDLE.

Test Plan:
- Two-beat pack:
  - Stimulus: base=0x010, count=2, beats 48'h665544332211 then 48'hCCBBAA998877 back-to-back.
  - Response: writes 0x010=32'h44332211, 0x011=32'h88776655, 0x012=32'hCCBBAA99. One done pulse coincident with the last wr_en; irq=1 afterwards.
- Odd count with padding:
  - Stimulus: count=1, beat 48'h665544332211.
  - Response: writes 32'h44332211, then 32'h00006655. Exactly 2 wr_en pulses.
- Zero count:
  - Stimulus: start with count=0.
  - Response: done high the cycle after start, no wr_en, busy never high.
- Throughput and backpressure:
  - Stimulus: count=6, s_valid held high, incrementing patterns.
  - Response: 9 writes at consecutive addresses with no gaps after the first. s_ready drops exactly when L=80. Data is bit-exact against the reference packer.
- Wrap, irrelevant start, reset and irq_clr:
  - Stimulus: base=0x3FF, count=2.
  - Response: addresses 0x3FF, 0x000, 0x001.
  - A start during busy is ignored.
  - Asserting rst mid-run returns the block to IDLE: no further wr_en, no done.
  - irq_clr in the same cycle as done leaves irq=1; a later irq_clr clears it.
